cgra_beat_upsizer: RTL and testbench

//  Beat-to-packet upsizer between the DMA RX read path and the CGRA AXIS bridge.
//  - Collects BEATS_PER_PKT consecutive BEAT_W-bit beats, in memory order, into one AXIS_W-bit packet word.
//  - Enforces packet framing with tlast; checks the pad bits above PKT_W.
//  - Double-buffered: one packet is assembled while the previous one waits on m_axis_tready.

---
 rtl/cgra_beat_upsizer.sv | 238 +++++++++++++++++++++++
 tb/tb_cgra_beat_upsizer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_beat_upsizer.sv
// ---------------------------------------------------------------------------
// cgra_beat_upsizer
//
// Packs BEATS_PER_PKT consecutive BEAT_W-bit beats from the DMA RX read path
// into one AXIS_W-bit packet word for the CGRA AXIS bridge. Beat 0 of a
// packet occupies the LSBs. tlast framing is enforced: short packets are
// dropped, and long packets are truncated to their first BEATS_PER_PKT beats.
// Bits [AXIS_W-1:PKT_W] of each emitted packet are pad and must be zero.
// The assembly buffer and the output register are separate, so one packet can
// be assembled while the previous one waits on m_axis_tready.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Once m_axis_tvalid is asserted, m_axis_tdata holds and tvalid
// stays high until that transfer, except when flush or reset discard it.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   s_beat_*          input beat stream (tdata/tvalid/tlast in, tready out)
//   m_axis_*          output packet stream (tdata/tvalid out, tready in)
//   flush             1-cycle pulse: discard partial and buffered packets
//   err_clr           clear sticky error flags
//   err_len           sticky: tlast framing error seen
//   err_pad           sticky: nonzero pad bits in an emitted packet
//   pkt_count         packets handed off on m_axis, wraps modulo 2^32
//   dbg_state         current FSM state (0 COLLECT, 1 FULL, 2 DROP)
// ---------------------------------------------------------------------------
module cgra_beat_upsizer #(
    parameter int BEAT_W        = 64,
    parameter int BEATS_PER_PKT = 3,
    parameter int AXIS_W        = 192,
    parameter int PKT_W         = 185
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BEAT_W-1:0] s_beat_tdata,
    input  logic              s_beat_tvalid,
    input  logic              s_beat_tlast,
    output logic              s_beat_tready,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              flush,
    input  logic              err_clr,
    output logic              err_len,
    output logic              err_pad,
    output logic [31:0]       pkt_count,
    output logic [1:0]        dbg_state
);

    if (AXIS_W != BEAT_W * BEATS_PER_PKT) begin : g_width_check
        $error("cgra_beat_upsizer: AXIS_W must equal BEAT_W*BEATS_PER_PKT");
    end

    localparam int IDX_W = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_PER_PKT - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_FULL    = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [AXIS_W-1:0]   r_asm;
    logic [AXIS_W-1:0]   w_asm_nxt;
    logic                r_pend;      // assembly buffer holds a complete packet
    logic                w_pend_nxt;
    logic [AXIS_W-1:0]   r_out;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic                r_err_len;
    logic                r_err_pad;
    logic [31:0]         r_pkt_count;

    logic                w_tready;
    logic                w_acc;
    logic                w_hs;
    logic                w_out_free;
    logic                w_load;      // output register captures w_load_data
    logic [AXIS_W-1:0]   w_load_data;
    logic [AXIS_W-1:0]   w_complete;
    logic                w_set_len;
    logic                w_set_pad;
    logic                w_pad_nz;

    assign w_acc      = s_beat_tvalid & w_tready;
    assign w_hs       = r_out_valid & m_axis_tready;
    // The output register can take a new packet if empty or draining now.
    assign w_out_free = ~r_out_valid | w_hs;

    // Final beat of a packet merged with the slots already collected.
    always_comb begin
        w_complete = r_asm;
        w_complete[(BEATS_PER_PKT-1)*BEAT_W +: BEAT_W] = s_beat_tdata;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_asm_nxt   = r_asm;
        w_pend_nxt  = r_pend;
        w_load      = 1'b0;
        w_load_data = r_asm;
        w_set_len   = 1'b0;

        case (r_state)
            ST_COLLECT: begin
                if (w_acc) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt = '0;
                        if (w_out_free) begin
                            w_load      = 1'b1;
                            w_load_data = w_complete;
                        end else begin
                            w_asm_nxt  = w_complete;
                            w_pend_nxt = 1'b1;
                        end
                        if (!s_beat_tlast) begin
                            // Long packet: keep the first beats, skip the rest.
                            w_set_len   = 1'b1;
                            w_state_nxt = ST_DROP;
                        end else if (!w_out_free) begin
                            w_state_nxt = ST_FULL;
                        end
                    end else if (s_beat_tlast) begin
                        // Short packet: discard what was collected.
                        w_idx_nxt = '0;
                        w_set_len = 1'b1;
                    end else begin
                        for (int k = 0; k < BEATS_PER_PKT; k++) begin
                            if (r_idx == IDX_W'(k)) begin
                                w_asm_nxt[k*BEAT_W +: BEAT_W] = s_beat_tdata;
                            end
                        end
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end

            ST_FULL: begin
                if (w_hs) begin
                    w_load      = 1'b1;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = ST_COLLECT;
                end
            end

            ST_DROP: begin
                if (r_pend && w_out_free) begin
                    w_load     = 1'b1;
                    w_pend_nxt = 1'b0;
                end
                if (w_acc && s_beat_tlast) begin
                    w_state_nxt = (r_pend && !w_out_free) ? ST_FULL : ST_COLLECT;
                end
            end

            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase

        // Flush discards everything buffered, including a beat taken this cycle.
        if (flush) begin
            w_state_nxt = ST_COLLECT;
            w_idx_nxt   = '0;
            w_pend_nxt  = 1'b0;
            w_load      = 1'b0;
            w_set_len   = 1'b0;
        end
    end

    assign w_pad_nz  = |(w_load_data >> PKT_W);
    assign w_set_pad = w_load & w_pad_nz;

    always_comb begin
        w_out_valid_nxt = r_out_valid;
        if (flush) begin
            w_out_valid_nxt = 1'b0;
        end else if (w_load) begin
            w_out_valid_nxt = 1'b1;
        end else if (w_hs) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_asm       <= '0;
            r_pend      <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_pad   <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_asm       <= w_asm_nxt;
            r_pend      <= w_pend_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_load) begin
                r_out <= w_load_data;
            end
            // A new error in the clear cycle keeps the flag set.
            r_err_len   <= (r_err_len & ~err_clr) | w_set_len;
            r_err_pad   <= (r_err_pad & ~err_clr) | w_set_pad;
            r_pkt_count <= r_pkt_count + {31'd0, w_hs};
        end
    end

    // Outputs
    always_comb begin
        w_tready      = (r_state != ST_FULL);
        s_beat_tready = w_tready;
        m_axis_tdata  = r_out;
        m_axis_tvalid = r_out_valid;
        err_len       = r_err_len;
        err_pad       = r_err_pad;
        pkt_count     = r_pkt_count;
        dbg_state     = r_state;
    end

endmodule

// File: tb/tb_cgra_beat_upsizer.sv
module tb_cgra_beat_upsizer;

    localparam int BEAT_W = 64;
    localparam int AXIS_W = 192;

    logic              clk;
    logic              reset;
    logic [BEAT_W-1:0] s_beat_tdata;
    logic              s_beat_tvalid;
    logic              s_beat_tlast;
    logic              s_beat_tready;
    logic [AXIS_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              flush;
    logic              err_clr;
    logic              err_len;
    logic              err_pad;
    logic [31:0]       pkt_count;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0]       exp_cnt;
    logic [AXIS_W-1:0] exp_q[$];
    logic [AXIS_W-1:0] got_q[$];

    cgra_beat_upsizer #(
        .BEAT_W(64), .BEATS_PER_PKT(3), .AXIS_W(192), .PKT_W(185)
    ) dut (
        .clk(clk), .reset(reset),
        .s_beat_tdata(s_beat_tdata), .s_beat_tvalid(s_beat_tvalid),
        .s_beat_tlast(s_beat_tlast), .s_beat_tready(s_beat_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .flush(flush), .err_clr(err_clr),
        .err_len(err_len), .err_pad(err_pad),
        .pkt_count(pkt_count), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: inputs change just after posedge, so the negedge view
    // equals what the next posedge samples.
    always @(negedge clk) begin
        if (!reset && m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic l);
        logic acc;
        int   n;
        s_beat_tdata  = d;
        s_beat_tlast  = l;
        s_beat_tvalid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            acc = s_beat_tready;
            tick();
            n++;
        end
        s_beat_tvalid = 1'b0;
        s_beat_tlast  = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout beat=%h not accepted within 100 cycles", d);
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int c = 0;
        while (got_q.size() < n && c < 60) begin
            tick();
            c++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got=%h exp=0", m_axis_tdata); end
        checks++; if (s_beat_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got=%b exp=1", s_beat_tready); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL rst_err_len got=%b exp=0", err_len); end
        checks++; if (err_pad !== 1'b0) begin errors++; $display("FAIL rst_err_pad got=%b exp=0", err_pad); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL rst_pkt_count got=%0d exp=0", pkt_count); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_single();
        logic [AXIS_W-1:0] e;
        e = {64'h3333, 64'h2222, 64'h1111};
        exp_q.delete(); got_q.delete();
        m_axis_tready = 1'b1;
        send_beat(64'h1111, 1'b0);
        send_beat(64'h2222, 1'b0);
        send_beat(64'h3333, 1'b1);
        // one cycle after the final beat
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t1_latency tvalid got=%b exp=1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== e) begin errors++; $display("FAIL t1_data got=%h exp=%h", m_axis_tdata, e); end
        tick();
        exp_cnt = exp_cnt + 1;
        checks++; if (pkt_count !== exp_cnt) begin errors++; $display("FAIL t1_pkt_count got=%0d exp=%0d", pkt_count, exp_cnt); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t1_tvalid_drop got=%b exp=0", m_axis_tvalid); end
    endtask

    task automatic test_backpressure();
        logic [AXIS_W-1:0] p1;
        p1 = {64'hA3, 64'hA2, 64'hA1};
        exp_q.delete(); got_q.delete();
        exp_q.push_back(p1);
        exp_q.push_back({64'hA6, 64'hA5, 64'hA4});
        m_axis_tready = 1'b0;
        send_beat(64'hA1, 1'b0);
        send_beat(64'hA2, 1'b0);
        send_beat(64'hA3, 1'b1);
        send_beat(64'hA4, 1'b0);
        send_beat(64'hA5, 1'b0);
        send_beat(64'hA6, 1'b1);
        checks++; if (s_beat_tready !== 1'b0) begin errors++; $display("FAIL t2_tready_drop got=%b exp=0", s_beat_tready); end
        repeat (10) tick();
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t2_stall_tvalid got=%b exp=1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== p1) begin errors++; $display("FAIL t2_stall_data got=%h exp=%h", m_axis_tdata, p1); end
        checks++; if (s_beat_tready !== 1'b0) begin errors++; $display("FAIL t2_stall_tready got=%b exp=0", s_beat_tready); end
        m_axis_tready = 1'b1;
        wait_got(2);
        exp_cnt = exp_cnt + 2;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL t2_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL t2_pkt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (pkt_count !== exp_cnt) begin errors++; $display("FAIL t2_pkt_count got=%0d exp=%0d", pkt_count, exp_cnt); end
        checks++; if (s_beat_tready !== 1'b1) begin errors++; $display("FAIL t2_tready_back got=%b exp=1", s_beat_tready); end
    endtask

    task automatic test_short();
        exp_q.delete(); got_q.delete();
        exp_q.push_back({64'hB3, 64'hB2, 64'hB1});
        m_axis_tready = 1'b1;
        send_beat(64'hC1, 1'b0);
        // err_clr coincides with the new framing error: the error wins
        err_clr = 1'b1;
        send_beat(64'hC2, 1'b1);
        err_clr = 1'b0;
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL t3_err_len got=%b exp=1", err_len); end
        send_beat(64'hB1, 1'b0);
        send_beat(64'hB2, 1'b0);
        send_beat(64'hB3, 1'b1);
        wait_got(1);
        exp_cnt = exp_cnt + 1;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL t3_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL t3_pkt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (pkt_count !== exp_cnt) begin errors++; $display("FAIL t3_pkt_count got=%0d exp=%0d", pkt_count, exp_cnt); end
        pulse_err_clr();
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL t3_err_clr got=%b exp=0", err_len); end
    endtask

    task automatic test_long();
        exp_q.delete(); got_q.delete();
        exp_q.push_back({64'hD3, 64'hD2, 64'hD1});
        exp_q.push_back({64'hE3, 64'hE2, 64'hE1});
        m_axis_tready = 1'b1;
        send_beat(64'hD1, 1'b0);
        send_beat(64'hD2, 1'b0);
        send_beat(64'hD3, 1'b0);
        send_beat(64'hD4, 1'b1);
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL t4_err_len got=%b exp=1", err_len); end
        send_beat(64'hE1, 1'b0);
        send_beat(64'hE2, 1'b0);
        send_beat(64'hE3, 1'b1);
        wait_got(2);
        exp_cnt = exp_cnt + 2;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL t4_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL t4_pkt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (pkt_count !== exp_cnt) begin errors++; $display("FAIL t4_pkt_count got=%0d exp=%0d", pkt_count, exp_cnt); end
        pulse_err_clr();
    endtask

    task automatic test_long_stalled();
        exp_q.delete(); got_q.delete();
        exp_q.push_back({64'hF3, 64'hF2, 64'hF1});
        exp_q.push_back({64'h53, 64'h52, 64'h51});
        exp_q.push_back({64'h63, 64'h62, 64'h61});
        m_axis_tready = 1'b0;
        send_beat(64'hF1, 1'b0);
        send_beat(64'hF2, 1'b0);
        send_beat(64'hF3, 1'b1);
        send_beat(64'h51, 1'b0);
        send_beat(64'h52, 1'b0);
        send_beat(64'h53, 1'b0);
        // DROP keeps accepting while the truncated packet waits
        checks++; if (s_beat_tready !== 1'b1) begin errors++; $display("FAIL t4s_drop_tready got=%b exp=1", s_beat_tready); end
        send_beat(64'h54, 1'b1);
        checks++; if (s_beat_tready !== 1'b0) begin errors++; $display("FAIL t4s_full_tready got=%b exp=0", s_beat_tready); end
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL t4s_err_len got=%b exp=1", err_len); end
        m_axis_tready = 1'b1;
        send_beat(64'h61, 1'b0);
        send_beat(64'h62, 1'b0);
        send_beat(64'h63, 1'b1);
        wait_got(3);
        exp_cnt = exp_cnt + 3;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL t4s_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL t4s_pkt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (pkt_count !== exp_cnt) begin errors++; $display("FAIL t4s_pkt_count got=%0d exp=%0d", pkt_count, exp_cnt); end
        pulse_err_clr();
    endtask

    task automatic test_pad();
        logic [AXIS_W-1:0] e;
        e = {64'h4000_0000_0000_0003, 64'h2, 64'h1};
        exp_q.delete(); got_q.delete();
        exp_q.push_back(e);
        m_axis_tready = 1'b1;
        checks++; if (err_pad !== 1'b0) begin errors++; $display("FAIL t5_err_pad_pre got=%b exp=0", err_pad); end
        send_beat(64'h1, 1'b0);
        send_beat(64'h2, 1'b0);
        send_beat(64'h4000_0000_0000_0003, 1'b1);
        checks++; if (err_pad !== 1'b1) begin errors++; $display("FAIL t5_err_pad got=%b exp=1", err_pad); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL t5_err_len got=%b exp=0", err_len); end
        wait_got(1);
        exp_cnt = exp_cnt + 1;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL t5_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL t5_pkt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        pulse_err_clr();
        checks++; if (err_pad !== 1'b0) begin errors++; $display("FAIL t5_err_clr got=%b exp=0", err_pad); end
    endtask

    task automatic test_flush();
        exp_q.delete(); got_q.delete();
        exp_q.push_back({64'h73, 64'h72, 64'h71});
        m_axis_tready = 1'b1;
        send_beat(64'h91, 1'b0);
        send_beat(64'h92, 1'b0);
        pulse_flush();
        send_beat(64'h71, 1'b0);
        send_beat(64'h72, 1'b0);
        send_beat(64'h73, 1'b1);
        wait_got(1);
        exp_cnt = exp_cnt + 1;
        // flush while a finished packet is stalled on the output
        m_axis_tready = 1'b0;
        send_beat(64'h81, 1'b0);
        send_beat(64'h82, 1'b0);
        send_beat(64'h83, 1'b1);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t6_pre_flush_tvalid got=%b exp=1", m_axis_tvalid); end
        pulse_flush();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t6_flush_tvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (s_beat_tready !== 1'b1) begin errors++; $display("FAIL t6_flush_tready got=%b exp=1", s_beat_tready); end
        checks++; if (pkt_count !== exp_cnt) begin errors++; $display("FAIL t6_flush_pkt_count got=%0d exp=%0d", pkt_count, exp_cnt); end
        m_axis_tready = 1'b1;
        repeat (5) tick();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL t6_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL t6_pkt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_stalled();
        exp_q.delete(); got_q.delete();
        exp_q.push_back({64'hC3, 64'hC2, 64'hC1});
        m_axis_tready = 1'b0;
        send_beat(64'h11, 1'b0);
        send_beat(64'h12, 1'b1);
        send_beat(64'h21, 1'b0);
        send_beat(64'h22, 1'b0);
        send_beat(64'h23, 1'b1);
        send_beat(64'h31, 1'b0);
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL t6r_pre_err_len got=%b exp=1", err_len); end
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t6r_pre_tvalid got=%b exp=1", m_axis_tvalid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 32'd0;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t6r_tvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL t6r_tdata got=%h exp=0", m_axis_tdata); end
        checks++; if (s_beat_tready !== 1'b1) begin errors++; $display("FAIL t6r_tready got=%b exp=1", s_beat_tready); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL t6r_err_len got=%b exp=0", err_len); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL t6r_pkt_count got=%0d exp=0", pkt_count); end
        m_axis_tready = 1'b1;
        send_beat(64'hC1, 1'b0);
        send_beat(64'hC2, 1'b0);
        send_beat(64'hC3, 1'b1);
        wait_got(1);
        exp_cnt = exp_cnt + 1;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL t6r_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL t6r_pkt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (pkt_count !== exp_cnt) begin errors++; $display("FAIL t6r_post_pkt_count got=%0d exp=%0d", pkt_count, exp_cnt); end
    endtask

    initial begin
        reset         = 1'b1;
        s_beat_tdata  = '0;
        s_beat_tvalid = 1'b0;
        s_beat_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        flush         = 1'b0;
        err_clr       = 1'b0;
        exp_cnt       = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        test_reset();
        test_single();
        test_backpressure();
        test_short();
        test_long();
        test_long_stalled();
        test_pad();
        test_flush();
        test_reset_stalled();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
